// File: rtl/tdm_demux4.sv
// tdm_demux4 -- four-channel time-division demultiplexer.
//
// Receive end of the 4:1 select-mux link. A serial stream of W-bit samples,
// one per valid beat, is framed by a sync marker on slot 0. An internal slot
// counter, locked to sync, routes slots 0..3 into channel outputs a..d. All
// four outputs are published together once per complete frame.
//
// Optional feature: define TDM_DEMUX_PARITY_EN to add a fifth slot carrying
// an even-parity bit over slots 0..3. Frames whose parity does not match are
// discarded and reported on par_err. Without the macro, par_err is tied low
// and no parity logic exists.
module tdm_demux4 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         sync,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic         frame_valid,
  output logic         locked,
  output logic         sync_err,
  output logic         par_err
);

  // Frame geometry: the last slot index is where a frame completes.
`ifdef TDM_DEMUX_PARITY_EN
  localparam logic [2:0] LAST_SLOT = 3'd4;
`else
  localparam logic [2:0] LAST_SLOT = 3'd3;
`endif

  // Framing FSM states.
  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0]   state;
  logic [2:0]   slot;
  logic [W-1:0] shadow0;
  logic [W-1:0] shadow1;
  logic [W-1:0] shadow2;
`ifdef TDM_DEMUX_PARITY_EN
  logic [W-1:0] shadow3;
  logic         parity_calc;
  logic         parity_ok;
  logic         par_err_q;
`endif

  // Beat classification, all qualified by din_valid.
  logic sync_beat;
  logic early_sync;
  logic missing_sync;
  logic mid_store;
  logic final_beat;
  logic frame_commit;
  logic parity_fail;

`ifdef TDM_DEMUX_PARITY_EN
  // Even parity over every bit of slots 0..3 compared against bit 0 of slot 4.
  always_comb begin
    parity_calc = ^{shadow0, shadow1, shadow2, shadow3};
    parity_ok   = (din[0] == parity_calc);
  end
`endif

  // Classify the current beat against the framing state.
  always_comb begin
    sync_beat    = 1'b0;
    early_sync   = 1'b0;
    missing_sync = 1'b0;
    mid_store    = 1'b0;
    final_beat   = 1'b0;
    frame_commit = 1'b0;
    parity_fail  = 1'b0;
    if (din_valid) begin
      if (sync) begin
        // Any valid sync beat is taken as slot 0, locked or not.
        sync_beat  = 1'b1;
        early_sync = (state == ST_LOCKED) && (slot != 3'd0);
      end else if (state == ST_LOCKED) begin
        if (slot == 3'd0) begin
          missing_sync = 1'b1;
        end else if (slot == LAST_SLOT) begin
          final_beat = 1'b1;
        end else begin
          mid_store = 1'b1;
        end
      end
    end
`ifdef TDM_DEMUX_PARITY_EN
    frame_commit = final_beat && parity_ok;
    parity_fail  = final_beat && !parity_ok;
`else
    frame_commit = final_beat;
    parity_fail  = 1'b0;
`endif
  end

  // Framing FSM: lock on the first sync, drop lock when slot 0 lacks sync.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_UNLOCKED;
    end else if (sync_beat) begin
      state <= ST_LOCKED;
    end else if (missing_sync) begin
      state <= ST_UNLOCKED;
    end
  end

  // Slot counter: sync restarts at 1, stores advance, the last slot wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot <= 3'd0;
    end else if (sync_beat) begin
      slot <= 3'd1;
    end else if (missing_sync || final_beat) begin
      slot <= 3'd0;
    end else if (mid_store) begin
      slot <= slot + 3'd1;
    end
  end

  // Shadow registers hold the in-flight frame until its last slot arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow0 <= '0;
      shadow1 <= '0;
      shadow2 <= '0;
`ifdef TDM_DEMUX_PARITY_EN
      shadow3 <= '0;
`endif
    end else if (sync_beat) begin
      shadow0 <= din;
    end else if (mid_store) begin
      case (slot)
        3'd1:    shadow1 <= din;
        3'd2:    shadow2 <= din;
`ifdef TDM_DEMUX_PARITY_EN
        3'd3:    shadow3 <= din;
`endif
        default: ;
      endcase
    end
  end

  // Channel outputs load all together, only on a completed good frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      c <= '0;
      d <= '0;
    end else if (frame_commit) begin
      a <= shadow0;
      b <= shadow1;
      c <= shadow2;
`ifdef TDM_DEMUX_PARITY_EN
      d <= shadow3;
`else
      d <= din;
`endif
    end
  end

  // Single-cycle status pulses for frame completion and framing errors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= frame_commit;
      sync_err    <= early_sync || missing_sync;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  // Parity mismatch pulse; the frame is dropped but lock is kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= parity_fail;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = parity_fail;
`endif

  assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4 -- directed self-checking bench for tdm_demux4 (W=1).
// Runs the four-slot scenarios by default, the parity scenarios when
// TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux4;

  localparam int W = 1;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid;
  logic         sync;
  logic [W-1:0] a, b, c, d;
  logic         frame_valid;
  logic         locked;
  logic         sync_err;
  logic         par_err;

  int tests_run;
  int tests_failed;

  tdm_demux4 #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .sync       (sync),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .frame_valid(frame_valid),
    .locked     (locked),
    .sync_err   (sync_err),
    .par_err    (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and tally the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one beat for a single clock edge, then sample #1 after that edge.
  task automatic applyStimulus(input logic v, input logic s, input logic [W-1:0] x);
    @(negedge clk);
    din_valid = v;
    sync      = s;
    din       = x;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sync      = 1'b0;
    din       = '0;
  endtask

  // Hold reset for n edges, optionally with a beat presented alongside it.
  task automatic applyReset(input int n, input logic v, input logic s);
    @(negedge clk);
    rst_n     = 1'b0;
    din_valid = v;
    sync      = s;
    din       = '1;
    repeat (n) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    din_valid = 1'b0;
    sync      = 1'b0;
    din       = '0;
  endtask

  // Idle cycles with no valid beats, sampling #1 after the last edge.
  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] outs();
    return {a[0], b[0], c[0], d[0]};
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b1;
    din_valid    = 1'b0;
    sync         = 1'b0;
    din          = '0;

    // Reset state.
    applyReset(2, 1'b0, 1'b0);
    checkOutput("reset_abcd", {28'd0, outs()}, 32'h0);
    checkOutput("reset_fv", {31'd0, frame_valid}, 32'h0);
    checkOutput("reset_locked", {31'd0, locked}, 32'h0);
    checkOutput("reset_sync_err", {31'd0, sync_err}, 32'h0);
    checkOutput("reset_par_err", {31'd0, par_err}, 32'h0);

`ifdef TDM_DEMUX_PARITY_EN
    // Good frame 1,0,0,0 with parity 1.
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("p_locked", {31'd0, locked}, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("p_pre_fv", {31'd0, frame_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("p_good_abcd", {28'd0, outs()}, 32'h8);
    checkOutput("p_good_fv", {31'd0, frame_valid}, 32'h1);
    checkOutput("p_good_par_err", {31'd0, par_err}, 32'h0);

    // Frame 1,1,0,0 with parity 1 is a mismatch.
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("p_bad_par_err", {31'd0, par_err}, 32'h1);
    checkOutput("p_bad_fv", {31'd0, frame_valid}, 32'h0);
    checkOutput("p_bad_abcd", {28'd0, outs()}, 32'h8);
    checkOutput("p_bad_locked", {31'd0, locked}, 32'h1);
    idleCycles(1);
    checkOutput("p_par_err_pulse", {31'd0, par_err}, 32'h0);

    // Good frame 0,1,1,1 with parity 1 still accepted after the mismatch.
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("p_good2_abcd", {28'd0, outs()}, 32'h7);

    // Reset mid-frame clears everything.
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyReset(1, 1'b1, 1'b0);
    checkOutput("p_midrst_abcd", {28'd0, outs()}, 32'h0);
    checkOutput("p_midrst_locked", {31'd0, locked}, 32'h0);
    checkOutput("p_midrst_fv", {31'd0, frame_valid}, 32'h0);
`else
    // Basic frame 1,0,1,1 on consecutive beats.
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t1_locked", {31'd0, locked}, 32'h1);
    checkOutput("t1_fv_beat1", {31'd0, frame_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t1_fv_beat3", {31'd0, frame_valid}, 32'h0);
    checkOutput("t1_abcd_early", {28'd0, outs()}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t1_abcd", {28'd0, outs()}, 32'hB);
    checkOutput("t1_fv", {31'd0, frame_valid}, 32'h1);
    idleCycles(1);
    checkOutput("t1_fv_pulse", {31'd0, frame_valid}, 32'h0);
    checkOutput("t1_abcd_hold", {28'd0, outs()}, 32'hB);

    // Same frame with 3-cycle gaps between beats.
    applyStimulus(1'b1, 1'b1, 1'b1);
    idleCycles(3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(3);
    applyStimulus(1'b1, 1'b0, 1'b1);
    idleCycles(3);
    checkOutput("t2_fv_gap", {31'd0, frame_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t2_abcd", {28'd0, outs()}, 32'hB);
    checkOutput("t2_fv", {31'd0, frame_valid}, 32'h1);

    // Five beats before any sync are dropped, then a sync frame 0,1,0,1.
    applyReset(1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t3_unlocked", {31'd0, locked}, 32'h0);
    checkOutput("t3_abcd_zero", {28'd0, outs()}, 32'h0);
    checkOutput("t3_no_fv", {31'd0, frame_valid}, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t3_abcd", {28'd0, outs()}, 32'h5);

    // Early sync discards the partial frame and restarts at slot 0.
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t4_sync_err", {31'd0, sync_err}, 32'h1);
    checkOutput("t4_abcd_hold", {28'd0, outs()}, 32'h5);
    checkOutput("t4_locked", {31'd0, locked}, 32'h1);
    checkOutput("t4_no_fv", {31'd0, frame_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t4_sync_err_pulse", {31'd0, sync_err}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t4_abcd", {28'd0, outs()}, 32'h6);
    checkOutput("t4_fv", {31'd0, frame_valid}, 32'h1);

    // Missing sync at slot 0 drops lock, then a new sync frame relocks.
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t5_sync_err", {31'd0, sync_err}, 32'h1);
    checkOutput("t5_unlocked", {31'd0, locked}, 32'h0);
    checkOutput("t5_abcd_hold", {28'd0, outs()}, 32'h6);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t5_relocked", {31'd0, locked}, 32'h1);
    checkOutput("t5_no_err", {31'd0, sync_err}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t5_abcd", {28'd0, outs()}, 32'hE);

    // Sync with din_valid low mid-frame is ignored.
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("t6_no_err", {31'd0, sync_err}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t6_abcd", {28'd0, outs()}, 32'h1);
    checkOutput("t6_fv", {31'd0, frame_valid}, 32'h1);

    // Reset mid-frame, with a sync beat presented during reset.
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyReset(1, 1'b1, 1'b1);
    checkOutput("t7_abcd", {28'd0, outs()}, 32'h0);
    checkOutput("t7_locked", {31'd0, locked}, 32'h0);
    checkOutput("t7_fv", {31'd0, frame_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t7_still_unlocked", {31'd0, locked}, 32'h0);
    checkOutput("t7_no_err", {31'd0, sync_err}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receive end of the 4:1 select-mux path. It accepts a serial stream of W-bit samples, one per valid beat, framed by a sync marker on slot 0. It routes slots 0..3 to channel outputs a, b, c, d and publishes all four together once per complete frame. It sits after the link that serialises the mux inputs and replaces the s1/s2 select with an internal slot counter locked to sync.

## Interface
- W, default 1: width of each sample and of each channel output.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- din  input  W  serial sample for the current slot.
- din_valid  input  1  beat qualifier; din and sync are sampled only when high.
- sync  input  1  frame marker; high on the slot-0 beat.
- a, b, c, d  output  W  registered channel samples for slots 0..3; held between frames.
- frame_valid  output  1  one-cycle pulse when a..d update.
- locked  output  1  high while aligned to the frame.
- sync_err  output  1  one-cycle pulse on a framing violation.
- par_err  output  1  one-cycle pulse on a parity mismatch; constant 0 when parity is compiled out.

## Operation
- N = 4 slots per frame, or 5 with parity (see Configuration).
- Internal state:
  - slot counter 0..N-1.
  - shadow registers for slots 0..2.
  - FSM with states UNLOCKED and LOCKED.
- Beats with din_valid=0 change nothing. Gaps of any length are legal at any slot. sync with din_valid=0 is ignored.
- UNLOCKED:
  - Beats without sync are dropped.
  - A beat with sync stores din into shadow[0], sets slot=1, and moves to LOCKED.
- LOCKED, slot 0:
  - Beat with sync: store into shadow[0], slot=1.
  - Beat without sync: sync_err pulses, the beat is dropped, slot=0, and the FSM moves to UNLOCKED.
- LOCKED, slot k != 0:
  - Beat without sync: store into shadow[k], slot=k+1.
  - Beat with sync (early sync): sync_err pulses and the partial frame is discarded (a..d untouched). The beat is taken as slot 0: shadow[0]=din, slot=1, FSM stays LOCKED.
- Frame completion, on the beat with slot = N-1 and no sync:
  - a..c load from shadow[0..2]; d loads from the slot-3 sample (din directly when N=4).
  - frame_valid pulses; slot wraps to 0.
- Only complete frames reach the outputs. a..d never show a mix of two frames.

## Timing
- All outputs are registered and update on the clk edge that samples the relevant beat.
- Latency: a..d and frame_valid change on the same edge that samples the final slot beat. frame_valid is high for exactly the following cycle.
- sync_err and par_err are high for exactly one cycle after the offending beat's edge.
- locked rises on the edge that accepts the first sync beat. It falls on the edge that detects a missing sync at slot 0.
- Reset (rst_n=0 at an edge) overrides everything, including an in-flight frame:
  - a=b=c=d=0; frame_valid=0, sync_err=0, par_err=0, locked=0.
  - slot=0, shadow registers cleared, FSM in UNLOCKED.
  - A beat presented in the reset cycle is dropped.
- Maximum throughput: one beat per cycle, i.e. one frame every N cycles.

## Configuration
- TDM_DEMUX_PARITY_EN defined:
  - N=5; slot 4 carries the even-parity bit (bit 0 of din), equal to the XOR-reduction of all bits of slots 0..3.
  - The slot-3 sample is held in a fourth shadow register.
  - On the slot-4 beat with a match: a..d update and frame_valid pulses.
  - On a mismatch: par_err pulses, a..d are unchanged, frame_valid stays 0, and locked is unaffected.
- TDM_DEMUX_PARITY_EN undefined:
  - N=4; par_err is tied to 0 and no parity logic exists.

## Test plan
- Reset, then sync+din=1 followed by 0,1,1 on consecutive valid beats (W=1, no parity) -> locked=1 after beat 1; a=1,b=0,c=1,d=1 with a single frame_valid pulse after beat 4.
- Same frame with din_valid=0 gaps of 3 cycles between beats -> identical outputs; frame_valid only after the 4th valid beat.
- 5 valid beats before any sync -> outputs stay 0, locked=0. Then a full sync frame 0,1,0,1 -> a=0,b=1,c=0,d=1.
- LOCKED, send slots 0,1 (values 1,1), then a sync beat din=0 -> sync_err pulse, a..d unchanged. The next 3 beats 1,1,0 -> a=0,b=1,c=1,d=0.
- LOCKED, slot-0 beat without sync -> sync_err pulse, locked=0, outputs held. A later sync frame relocks.
- Parity build: frame 1,0,0,0 with parity 1 -> update. Frame 1,1,0,0 with parity 1 -> par_err pulse, a..d keep 1,0,0,0. Assert rst_n=0 mid-frame -> all outputs 0 next cycle.
